// File: rtl/uart_hakem_pkt.sv
// Shared types and helpers for the round-robin UART transmitter arbiter.
package uart_hakem_pkt;

  typedef enum logic [1:0] {
    SEC     = 2'd0,
    SUN     = 2'd1,
    KILITLI = 2'd2
  } durum_t;

  localparam int UART_VERI_GEN = 8;

  // Width of an owner index; a single requester still needs one bit.
  function automatic int ist_gen(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_secici.sv
// Combinational round-robin picker: searches from son_sahip_i+1 upward, wrapping modulo N.
module uart_rr_secici
  import uart_hakem_pkt::*;
#(
  parameter int N = 4,
  parameter int W = ist_gen(N)
) (
  input  logic [N-1:0] istek_i,
  input  logic [W-1:0] son_sahip_i,
  output logic         var_o,
  output logic [W-1:0] kazanan_o
);

  // Wrap uses an integer modulo so non-power-of-two N never lands on a phantom index.
  always_comb begin
    int idx;
    var_o     = 1'b0;
    kazanan_o = '0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(son_sahip_i) + k) % N;
      if (!var_o && istek_i[W'(idx)]) begin
        var_o     = 1'b1;
        kazanan_o = W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_verici_hakem.sv
// Round-robin arbiter sharing one UART transmitter between N_IST byte-stream requesters.
// Optional lock timeout enabled by defining UART_HAKEM_ZAMAN_ASIMI_EN.
module uart_verici_hakem
  import uart_hakem_pkt::*;
#(
  parameter int N_IST       = 4,
  parameter int KILIT_ZAMAN = 1000000
) (
  input  logic                             clk_g,
  input  logic                             rst_g,
  input  logic [N_IST-1:0]                 ist_gecerli,
  input  logic [UART_VERI_GEN*N_IST-1:0]   ist_veri,
  input  logic [N_IST-1:0]                 ist_son,
  output logic [N_IST-1:0]                 ist_hazir,
  output logic [UART_VERI_GEN-1:0]         ver_veri,
  output logic                             ver_gecerli,
  input  logic                             verici_hazir,
  output logic [ist_gen(N_IST)-1:0]        sahip,
  output logic                             mesgul
);

  localparam int SW = ist_gen(N_IST);

  durum_t                   durum_q, durum_d;
  logic [UART_VERI_GEN-1:0] tampon_q, tampon_d;
  logic                     son_r_q, son_r_d;
  logic [SW-1:0]            sahip_q, sahip_d;
  logic [SW-1:0]            son_sahip_q, son_sahip_d;
  logic                     bekle_q;
  logic                     sec_var;
  logic [SW-1:0]            sec_kazanan;
  logic [UART_VERI_GEN-1:0] veri_dizi [N_IST];

`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
  localparam int SAYAC_GEN = (KILIT_ZAMAN > 1) ? $clog2(KILIT_ZAMAN) : 1;
  logic [SAYAC_GEN-1:0] sayac_q, sayac_d;
`endif

  always_comb begin
    for (int i = 0; i < N_IST; i++) begin
      veri_dizi[i] = ist_veri[UART_VERI_GEN*i +: UART_VERI_GEN];
    end
  end

  uart_rr_secici #(
    .N (N_IST),
    .W (SW)
  ) u_secici (
    .istek_i     (ist_gecerli),
    .son_sahip_i (son_sahip_q),
    .var_o       (sec_var),
    .kazanan_o   (sec_kazanan)
  );

  // bekle_q keeps arbitration closed for one cycle after reset is released.
  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      durum_q     <= SEC;
      tampon_q    <= '0;
      son_r_q     <= 1'b0;
      sahip_q     <= '0;
      son_sahip_q <= SW'(N_IST - 1);
      bekle_q     <= 1'b1;
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
      sayac_q     <= '0;
`endif
    end else begin
      durum_q     <= durum_d;
      tampon_q    <= tampon_d;
      son_r_q     <= son_r_d;
      sahip_q     <= sahip_d;
      son_sahip_q <= son_sahip_d;
      bekle_q     <= 1'b0;
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
      sayac_q     <= sayac_d;
`endif
    end
  end

  always_comb begin
    durum_d     = durum_q;
    tampon_d    = tampon_q;
    son_r_d     = son_r_q;
    sahip_d     = sahip_q;
    son_sahip_d = son_sahip_q;
    ist_hazir   = '0;
    ver_gecerli = 1'b0;
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
    sayac_d     = sayac_q;
`endif
    unique case (durum_q)
      SEC: begin
        if (!bekle_q && sec_var) begin
          ist_hazir[sec_kazanan] = 1'b1;
          tampon_d = veri_dizi[sec_kazanan];
          son_r_d  = ist_son[sec_kazanan];
          sahip_d  = sec_kazanan;
          durum_d  = SUN;
        end
      end
      SUN: begin
        ver_gecerli = 1'b1;
        if (verici_hazir) begin
          if (son_r_q) begin
            son_sahip_d = sahip_q;
            durum_d     = SEC;
          end else begin
            durum_d = KILITLI;
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
            sayac_d = '0;
`endif
          end
        end
      end
      KILITLI: begin
        ist_hazir[sahip_q] = 1'b1;
        if (ist_gecerli[sahip_q]) begin
          tampon_d = veri_dizi[sahip_q];
          son_r_d  = ist_son[sahip_q];
          durum_d  = SUN;
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
        end else if (sayac_q == SAYAC_GEN'(KILIT_ZAMAN - 1)) begin
          son_sahip_d = sahip_q;
          durum_d     = SEC;
        end else begin
          sayac_d = sayac_q + 1'b1;
`endif
        end
      end
      default: durum_d = SEC;
    endcase
    if (rst_g) begin
      ist_hazir   = '0;
      ver_gecerli = 1'b0;
    end
  end

  assign ver_veri = tampon_q;
  assign sahip    = sahip_q;
  assign mesgul   = (durum_q != SEC) && !rst_g;

endmodule

// File: tb/tb_uart_verici_hakem.sv
// Directed self-checking bench for uart_verici_hakem (four requesters, KILIT_ZAMAN=16).
module tb_uart_verici_hakem;

  logic        clk_g = 1'b0;
  logic        rst_g;
  logic [3:0]  ist_gecerli;
  logic [31:0] ist_veri;
  logic [3:0]  ist_son;
  logic [3:0]  ist_hazir;
  logic [7:0]  ver_veri;
  logic        ver_gecerli;
  logic        verici_hazir;
  logic [1:0]  sahip;
  logic        mesgul;

  int checkCount = 0;
  int passCount  = 0;

  uart_verici_hakem #(
    .N_IST       (4),
    .KILIT_ZAMAN (16)
  ) dut (
    .clk_g        (clk_g),
    .rst_g        (rst_g),
    .ist_gecerli  (ist_gecerli),
    .ist_veri     (ist_veri),
    .ist_son      (ist_son),
    .ist_hazir    (ist_hazir),
    .ver_veri     (ver_veri),
    .ver_gecerli  (ver_gecerli),
    .verici_hazir (verici_hazir),
    .sahip        (sahip),
    .mesgul       (mesgul)
  );

  always #5 clk_g = ~clk_g;

  task automatic tick();
    @(posedge clk_g);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] g, input logic [31:0] v,
                               input logic [3:0] s, input logic h);
    ist_gecerli  = g;
    ist_veri     = v;
    ist_son      = s;
    verici_hazir = h;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Leaves the bench just after the first edge on which arbitration is open again.
  task automatic resetDut();
    rst_g = 1'b1;
    tick();
    tick();
    rst_g = 1'b0;
    tick();
  endtask

  initial begin
    rst_g = 1'b1;
    applyStimulus(4'h0, 32'h0, 4'h0, 1'b0);

    // Test 1: single byte from requester 0, including reset-time quiet outputs
    tick();
    applyStimulus(4'b0001, 32'h0000_0041, 4'b0001, 1'b0);
    tick();
    checkOutput("t1_rst_hazir", ist_hazir, 4'b0000);
    checkOutput("t1_rst_gecerli", ver_gecerli, 1'b0);
    checkOutput("t1_rst_mesgul", mesgul, 1'b0);
    rst_g = 1'b0;
    #1;
    checkOutput("t1_after_rst_hazir", ist_hazir, 4'b0000);
    tick();
    checkOutput("t1_grant", ist_hazir, 4'b0001);
    checkOutput("t1_mesgul_idle", mesgul, 1'b0);
    tick();
    applyStimulus(4'b0000, 32'h0, 4'h0, 1'b1);
    checkOutput("t1_ver_gecerli", ver_gecerli, 1'b1);
    checkOutput("t1_ver_veri", ver_veri, 8'h41);
    checkOutput("t1_sahip", sahip, 2'd0);
    checkOutput("t1_mesgul", mesgul, 1'b1);
    tick();
    checkOutput("t1_released", mesgul, 1'b0);
    checkOutput("t1_no_offer", ver_gecerli, 1'b0);

    // Test 2: all four requesting single-byte messages
    resetDut();
    applyStimulus(4'hF, 32'h4443_4241, 4'hF, 1'b1);
    for (int g = 0; g < 5; g++) begin
      checkOutput("t2_grant", ist_hazir, 32'(1) << (g % 4));
      tick();
      checkOutput("t2_byte", ver_veri, 8'h41 + 8'(g % 4));
      checkOutput("t2_hazir_sun", ist_hazir, 4'b0000);
      tick();
    end
    applyStimulus(4'h0, 32'h0, 4'h0, 1'b1);
    tick();

    // Test 3: 3-byte message from requester 1 with requester 2 waiting
    resetDut();
    applyStimulus(4'b0110, 32'h005A_4100, 4'b0100, 1'b1);
    checkOutput("t3_grant1", ist_hazir, 4'b0010);
    tick();
    applyStimulus(4'b0110, 32'h005A_4200, 4'b0100, 1'b1);
    checkOutput("t3_byteA", ver_veri, 8'h41);
    tick();
    checkOutput("t3_lock_hazir", ist_hazir, 4'b0010);
    checkOutput("t3_lock_sahip", sahip, 2'd1);
    tick();
    applyStimulus(4'b0110, 32'h005A_4300, 4'b0110, 1'b1);
    checkOutput("t3_byteB", ver_veri, 8'h42);
    checkOutput("t3_sun_hazir", ist_hazir, 4'b0000);
    tick();
    checkOutput("t3_lock2_hazir", ist_hazir, 4'b0010);
    tick();
    applyStimulus(4'b0100, 32'h005A_0000, 4'b0100, 1'b1);
    checkOutput("t3_byteC", ver_veri, 8'h43);
    tick();
    checkOutput("t3_grant2", ist_hazir, 4'b0100);
    tick();
    applyStimulus(4'b0000, 32'h0, 4'h0, 1'b1);
    checkOutput("t3_byte2", ver_veri, 8'h5A);
    tick();

    // Test 4: transmitter stalls for 100 cycles while a byte is offered
    resetDut();
    applyStimulus(4'b0001, 32'h0000_0077, 4'b0001, 1'b0);
    checkOutput("t4_grant", ist_hazir, 4'b0001);
    tick();
    applyStimulus(4'hF, 32'h0000_0099, 4'hF, 1'b0);
    for (int c = 0; c < 100; c++) begin
      checkOutput("t4_stable", {ist_hazir, ver_gecerli, ver_veri}, {4'b0000, 1'b1, 8'h77});
      tick();
    end
    applyStimulus(4'hF, 32'h0000_0099, 4'hF, 1'b1);
    tick();
    checkOutput("t4_next_grant", ist_hazir, 4'b0010);
    applyStimulus(4'h0, 32'h0, 4'h0, 1'b1);
    tick();
    tick();

    // Test 5: owner goes silent after a non-last byte
    resetDut();
    applyStimulus(4'b0101, 32'h0022_0011, 4'b0100, 1'b1);
    checkOutput("t5_grant0", ist_hazir, 4'b0001);
    tick();
    applyStimulus(4'b0100, 32'h0022_0011, 4'b0100, 1'b1);
    tick();
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
    for (int c = 0; c < 15; c++) tick();
    checkOutput("t5_still_locked", ist_hazir, 4'b0001);
    checkOutput("t5_mesgul", mesgul, 1'b1);
    tick();
    checkOutput("t5_released_grant2", ist_hazir, 4'b0100);
    checkOutput("t5_released_mesgul", mesgul, 1'b0);
`else
    for (int c = 0; c < 1000; c++) tick();
    checkOutput("t5_locked_hazir", ist_hazir, 4'b0001);
    checkOutput("t5_locked_mesgul", mesgul, 1'b1);
    checkOutput("t5_locked_gecerli", ver_gecerli, 1'b0);
`endif

    // Test 6: reset pulsed in KILITLI and in SUN
    resetDut();
    applyStimulus(4'b0001, 32'h0000_0031, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 32'h0, 4'h0, 1'b1);
    tick();
    checkOutput("t6_in_lock", {mesgul, ist_hazir}, {1'b1, 4'b0001});
    applyStimulus(4'hF, 32'h4443_4241, 4'hF, 1'b0);
    resetDut();
    checkOutput("t6_lock_rst_grant", ist_hazir, 4'b0001);
    tick();
    checkOutput("t6_in_sun", ver_gecerli, 1'b1);
    rst_g = 1'b1;
    tick();
    checkOutput("t6_sun_rst", {ver_gecerli, mesgul, ist_hazir}, {1'b0, 1'b0, 4'b0000});
    rst_g = 1'b0;
    #1;
    checkOutput("t6_bekle", ist_hazir, 4'b0000);
    tick();
    checkOutput("t6_sun_rst_grant", ist_hazir, 4'b0001);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
